// File: rtl/gpio_reg_decoder.sv
// Fabric-side responder for the PS GPIO register-write bus: synchronises w_clk strobes,
// pairs MSB-first bytes into 16-bit register writes and latches read-back data.
module gpio_reg_decoder #(
    parameter logic [15:0] PAIR_ADDR_MIN = 16'h0000,
    parameter logic [15:0] PAIR_ADDR_MAX = 16'h00FF,
    parameter int unsigned TIMEOUT_CYC   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out_bus,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_wide,
    input  logic [31:0] rd_data,
    output logic [7:0]  err_cnt,
    output logic        pending
);
    localparam int unsigned   TW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   PAIR_SPAN = PAIR_ADDR_MAX - PAIR_ADDR_MIN;

    logic [24:0]   s1;
    logic [24:0]   s2;
    logic          s3_wclk;
    logic [7:0]    held_byte;
    logic [15:0]   held_addr;
    logic [TW-1:0] timer;

    logic [15:0] cap_addr;
    logic [7:0]  cap_data;
    logic [15:0] rel_addr;
    logic        strobe;
    logic        in_pair;
    logic        same_pair;
    logic        timed_out;
    logic        err_event;

    logic unused_bits;
    assign unused_bits = ^gpio_in[31:25];

    always_comb begin
        cap_addr  = s2[15:0];
        cap_data  = s2[23:16];
        strobe    = s2[24] & ~s3_wclk;
        // Modular offset check: addr in [MIN, MAX] iff (addr - MIN) mod 2^16 <= MAX - MIN.
        rel_addr  = cap_addr - PAIR_ADDR_MIN;
        in_pair   = (rel_addr <= PAIR_SPAN);
        same_pair = pending && (held_addr == cap_addr);
        timed_out = pending && (timer == T_LAST);
        err_event = strobe ? (pending && (!in_pair || !same_pair)) : timed_out;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1           <= '0;
            s2           <= '0;
            s3_wclk      <= 1'b0;
            held_byte    <= '0;
            held_addr    <= '0;
            timer        <= '0;
            pending      <= 1'b0;
            err_cnt      <= '0;
            wr_valid     <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_wide      <= 1'b0;
            gpio_out_bus <= '0;
        end else begin
            s1       <= gpio_in[24:0];
            s2       <= s1;
            s3_wclk  <= s2[24];
            wr_valid <= 1'b0;

            if (wr_valid) begin
                gpio_out_bus <= rd_data;
            end
            if (err_event && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (strobe) begin
                if (!in_pair) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= cap_addr;
                    wr_data  <= {8'h00, cap_data};
                    wr_wide  <= 1'b0;
                    pending  <= 1'b0;
                end else if (same_pair) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= cap_addr;
                    wr_data  <= {held_byte, cap_data};
                    wr_wide  <= 1'b1;
                    pending  <= 1'b0;
                end else begin
                    // First byte of a pair, or a new pair address replacing an orphan.
                    held_byte <= cap_data;
                    held_addr <= cap_addr;
                    timer     <= '0;
                    pending   <= 1'b1;
                end
            end else if (pending) begin
                if (timed_out) begin
                    pending <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gpio_reg_decoder.sv
// Randomised self-checking bench for gpio_reg_decoder against a transaction-level
// model of the byte-pairing, timeout and error-count rules.
module tb_gpio_reg_decoder;
    localparam logic [15:0] PMIN = 16'h0000;
    localparam logic [15:0] PMAX = 16'h00FF;
    localparam int          TO   = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        wide;
        logic [31:0] cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out_bus;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_wide;
    logic [31:0] rd_data;
    logic [7:0]  err_cnt;
    logic        pending;

    logic        rd_force = 1'b0;
    logic [31:0] rd_val = '0;
    assign rd_data = rd_force ? rd_val : {wr_addr ^ 16'hBEEF, wr_addr};

    gpio_reg_decoder #(
        .PAIR_ADDR_MIN(PMIN),
        .PAIR_ADDR_MAX(PMAX),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_in(gpio_in),
        .gpio_out_bus(gpio_out_bus),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_wide(wr_wide),
        .rd_data(rd_data),
        .err_cnt(err_cnt),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t obs_q[$];
    always @(posedge clk) begin
        #1;
        if (wr_valid === 1'b1) obs_q.push_back('{wr_addr, wr_data, wr_wide, cyc});
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    wr_t         exp_q[$];
    logic        m_pend = 1'b0;
    logic [7:0]  m_held = '0;
    logic [15:0] m_haddr = '0;
    int          m_hcyc = 0;
    int          m_err = 0;
    logic [31:0] m_gob = '0;

    function automatic bit in_pair(input logic [15:0] a);
        return (int'(a) >= int'(PMIN)) && (int'(a) <= int'(PMAX));
    endfunction

    function automatic logic [31:0] rd_of(input logic [15:0] a);
        return rd_force ? rd_val : {a ^ 16'hBEEF, a};
    endfunction

    task automatic bump_err();
        m_err = (m_err < 255) ? m_err + 1 : 255;
    endtask

    // A held byte dies at the clock edge TO cycles after it was captured.
    task automatic settle(input int c);
        if (m_pend && (c - m_hcyc >= TO)) begin
            m_pend = 1'b0;
            bump_err();
        end
    endtask

    task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input int e);
        settle(e - 1);
        if (!in_pair(a)) begin
            if (m_pend) bump_err();
            m_pend = 1'b0;
            exp_q.push_back('{a, {8'h00, d}, 1'b0, e});
            m_gob = rd_of(a);
        end else if (m_pend && (m_haddr == a)) begin
            exp_q.push_back('{a, {m_held, d}, 1'b1, e});
            m_gob = rd_of(a);
            m_pend = 1'b0;
        end else begin
            if (m_pend) bump_err();
            m_pend  = 1'b1;
            m_held  = d;
            m_haddr = a;
            m_hcyc  = e;
        end
    endtask

    // One host write: w_clk high for hi clocks, then low for lo clocks. e = edge where it lands.
    task automatic send(input logic [15:0] a, input logic [7:0] d, input int hi, input int lo,
                        output int e);
        @(negedge clk);
        gpio_in = {7'($urandom), 1'b1, d, a};
        e = cyc + 3;
        model_edge(a, d, e);
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        gpio_in = $urandom & 32'hFEFF_FFFF;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        gpio_in = '0;
        @(negedge clk);
        rst = 1'b1;
        m_pend = 1'b0;
        m_err = 0;
        m_gob = '0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        gpio_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_bad++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
        n_cmp++; if (wr_data !== 16'h0) begin n_bad++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
        n_cmp++; if (wr_wide !== 1'b0) begin n_bad++; $display("FAIL rst_wr_wide: got %b want 0", wr_wide); end
        n_cmp++; if (gpio_out_bus !== 32'h0) begin n_bad++; $display("FAIL rst_gob: got %h want 0", gpio_out_bus); end
        n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL rst_err: got %h want 0", err_cnt); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending: got %b want 0", pending); end
        rst = 1'b1;
    endtask

    task automatic test_pair();
        int e;
        send(16'h0010, 8'h12, 2, 3, e);
        send(16'h0010, 8'h34, 2, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL pair_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL pair_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() > 0) begin
            n_cmp++; if (obs_q[0].data !== 16'h1234 || obs_q[0].wide !== 1'b1) begin n_bad++; $display("FAIL pair_value: got %h/%b want 1234/1", obs_q[0].data, obs_q[0].wide); end
        end
        n_cmp++; if (err_cnt !== m_err[7:0]) begin n_bad++; $display("FAIL pair_err: got %0d want %0d", err_cnt, m_err); end
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL pair_pending: got %b want %b", pending, m_pend); end
        n_cmp++; if (gpio_out_bus !== m_gob) begin n_bad++; $display("FAIL pair_gob: got %h want %h", gpio_out_bus, m_gob); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_single();
        int e;
        rd_force = 1'b1;
        rd_val = 32'h3;
        send(16'h0100, 8'h01, 2, 3, e);
        // send returns at the negedge one cycle after the strobe cycle
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_width: got %b want 0", wr_valid); end
        n_cmp++; if (gpio_out_bus !== 32'h3) begin n_bad++; $display("FAIL single_readback: got %h want 00000003", gpio_out_bus); end
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (err_cnt !== m_err[7:0]) begin n_bad++; $display("FAIL single_err: got %0d want %0d", err_cnt, m_err); end
        n_cmp++; if (gpio_out_bus !== m_gob) begin n_bad++; $display("FAIL single_gob: got %h want %h", gpio_out_bus, m_gob); end
        rd_force = 1'b0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mismatch();
        int e;
        do_reset();
        send(16'h0020, 8'hAA, 2, 3, e);
        send(16'h0021, 8'h55, 2, 3, e);
        send(16'h0021, 8'h66, 2, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL mismatch_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mismatch_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (err_cnt !== m_err[7:0] || err_cnt !== 8'd1) begin n_bad++; $display("FAIL mismatch_err: got %0d want %0d", err_cnt, m_err); end
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL mismatch_pending: got %b want %b", pending, m_pend); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        int e;
        int e2;
        do_reset();
        send(16'h0005, 8'h77, 2, 3, e);
        for (int g = 0; g < 40 && cyc < e + TO - 1; g++) @(negedge clk);
        settle(cyc);
        n_cmp++; if (pending !== m_pend || pending !== 1'b1) begin n_bad++; $display("FAIL timeout_before: got %b want %b", pending, m_pend); end
        @(negedge clk);
        settle(cyc);
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL timeout_drop: got %b want %b", pending, m_pend); end
        n_cmp++; if (err_cnt !== m_err[7:0]) begin n_bad++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, m_err); end
        for (int g = 0; g < 40 && cyc < e + 20; g++) @(negedge clk);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL timeout_nostrobe: got %0d want 0", obs_q.size()); end
        send(16'h0005, 8'hAB, 2, 3, e2);
        send(16'h0005, 8'hCD, 2, 3, e2);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL timeout_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (err_cnt !== m_err[7:0] || err_cnt !== 8'd1) begin n_bad++; $display("FAIL timeout_err_final: got %0d want %0d", err_cnt, m_err); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_long();
        int e;
        send(16'h0300, 8'h5A, 10, 3, e);
        send(16'h0060, 8'hC3, 10, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size() || obs_q.size() !== 1) begin n_bad++; $display("FAIL long_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL long_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL long_pending: got %b want %b", pending, m_pend); end
        n_cmp++; if (gpio_out_bus !== m_gob) begin n_bad++; $display("FAIL long_gob: got %h want %h", gpio_out_bus, m_gob); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_sweep();
        int e;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(16'(i), 8'h00, 1, 3, e);
            send(16'(i), 8'(i), 1, 3, e);
        end
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size() || obs_q.size() !== 256) begin n_bad++; $display("FAIL sweep_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sweep_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sweep_err: got %0d want 0", err_cnt); end
        n_cmp++; if (gpio_out_bus !== m_gob) begin n_bad++; $display("FAIL sweep_gob: got %h want %h", gpio_out_bus, m_gob); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_pair();
        int e;
        send(16'h0030, 8'h11, 2, 3, e);
        do_reset();
        n_cmp++; if ({wr_valid, wr_addr, wr_data, wr_wide} !== 34'h0) begin n_bad++; $display("FAIL midrst_wr: got %h want 0", {wr_valid, wr_addr, wr_data, wr_wide}); end
        n_cmp++; if (gpio_out_bus !== 32'h0) begin n_bad++; $display("FAIL midrst_gob: got %h want 0", gpio_out_bus); end
        n_cmp++; if (err_cnt !== 8'h0 || pending !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got err %0d pend %b want 0 0", err_cnt, pending); end
        send(16'h0030, 8'h22, 2, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL midrst_nostrobe: got %0d want 0", obs_q.size()); end
        n_cmp++; if (pending !== m_pend || pending !== 1'b1) begin n_bad++; $display("FAIL midrst_pending: got %b want %b", pending, m_pend); end
        n_cmp++; if (err_cnt !== m_err[7:0]) begin n_bad++; $display("FAIL midrst_err: got %0d want %0d", err_cnt, m_err); end
        send(16'h0030, 8'h33, 2, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i] || obs_q[i].data !== 16'h2233) begin n_bad++; $display("FAIL midrst_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturate();
        int e;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 1) ? 16'h0051 : 16'h0050, 8'($urandom), 1, 3, e);
        end
        send(16'h1234, 8'h9C, 1, 3, e);
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (err_cnt !== m_err[7:0] || err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_err: got %0d want %0d", err_cnt, m_err); end
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL sat_pending: got %b want %b", pending, m_pend); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sat_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int e;
        int hi;
        int lo;
        int sel;
        logic [15:0] a;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 5));
            if (sel < 4)       a = 16'h0040 + 16'(sel);
            else if (sel == 4) a = 16'h0100;
            else               a = 16'hFF00 | 16'($urandom_range(0, 255));
            hi = int'($urandom_range(1, 4));
            lo = ((hi >= 3) ? 1 : 4 - hi) + int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) lo = lo + int'($urandom_range(8, 16));
            send(a, 8'($urandom), hi, lo, e);
        end
        repeat (2) @(negedge clk);
        settle(cyc);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_wr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (err_cnt !== m_err[7:0]) begin n_bad++; $display("FAIL rand_err: got %0d want %0d", err_cnt, m_err); end
        n_cmp++; if (pending !== m_pend) begin n_bad++; $display("FAIL rand_pending: got %b want %b", pending, m_pend); end
        n_cmp++; if (gpio_out_bus !== m_gob) begin n_bad++; $display("FAIL rand_gob: got %h want %h", gpio_out_bus, m_gob); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        gpio_in = '0;
        test_reset();
        test_pair();
        test_single();
        test_mismatch();
        test_timeout();
        test_long();
        test_sweep();
        test_reset_mid_pair();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
